vend_dispenser: RTL

VEND_DISPENSER -- requirements
Module: vend_dispenser

---
 rtl/vend_dispenser.sv | 139 +++++++++++++
 1 files changed

// File: rtl/vend_dispenser.sv
// Vending dispenser controller: runs the product motor, then returns change one coin at a time
// through an acknowledged ejector. An ejector that stops acknowledging raises a sticky fault.
module vend_dispenser #(
    parameter int MOTOR_CYCLES  = 8,
    parameter int EJECT_TIMEOUT = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] item,
    input  logic [2:0] change_count,
    input  logic       eject_done,
    output logic [3:0] motor,
    output logic       eject,
    output logic [2:0] coins_paid,
    output logic       busy,
    output logic       done,
    output logic       reject,
    output logic       fault,
    output logic [2:0] fsm_state
);
    // Handshakes: start is a single-cycle request that is only looked at in IDLE.
    // Each eject pulse is answered by one eject_done pulse, which is only looked at in WAIT_ACK.

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        VEND     = 3'd1,
        EJECT    = 3'd2,
        WAIT_ACK = 3'd3,
        DONE     = 3'd4,
        FAULT    = 3'd5
    } state_t;

    localparam int MW = (MOTOR_CYCLES > 1) ? $clog2(MOTOR_CYCLES) : 1;
    localparam int TW = $clog2(EJECT_TIMEOUT + 1);
    localparam logic [MW-1:0] MOTOR_LAST   = MW'(MOTOR_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(EJECT_TIMEOUT);

    state_t        state;
    logic [2:0]    change_q;
    logic [MW-1:0] motor_cnt;
    logic [TW-1:0] wait_cnt;
    logic          multi_item;
    logic          empty_request;

    always_comb begin
        multi_item    = (item & (item - 4'd1)) != 4'd0;
        empty_request = (item == 4'd0) && (change_count == 3'd0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            change_q   <= '0;
            motor_cnt  <= '0;
            wait_cnt   <= '0;
            motor      <= '0;
            eject      <= 1'b0;
            coins_paid <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            reject     <= 1'b0;
            fault      <= 1'b0;
        end else begin
            eject  <= 1'b0;
            done   <= 1'b0;
            reject <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (multi_item || empty_request) begin
                            reject <= 1'b1;
                        end else begin
                            change_q   <= change_count;
                            coins_paid <= '0;
                            busy       <= 1'b1;
                            // The motor register doubles as the latched item selection.
                            if (item != 4'd0) begin
                                state     <= VEND;
                                motor     <= item;
                                motor_cnt <= '0;
                            end else begin
                                state <= EJECT;
                            end
                        end
                    end
                end
                VEND: begin
                    if (motor_cnt == MOTOR_LAST) begin
                        motor <= '0;
                        state <= EJECT;
                    end else begin
                        motor_cnt <= motor_cnt + MW'(1);
                    end
                end
                EJECT: begin
                    if (coins_paid == change_q) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        eject    <= 1'b1;
                        wait_cnt <= '0;
                        state    <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    // wait_cnt equals the number of cycles since the eject pulse, so an
                    // acknowledge seen while it reads EJECT_TIMEOUT still counts.
                    if (eject_done) begin
                        coins_paid <= coins_paid + 3'd1;
                        state      <= EJECT;
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        fault <= 1'b1;
                        state <= FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                FAULT: begin
                    fault <= 1'b1;
                    busy  <= 1'b1;
                    motor <= '0;
                end
                default: begin
                    busy  <= 1'b0;
                    motor <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign fsm_state = state;

endmodule
